operation: RTL and testbench
============================

# operation

9×9 box-mean filter core for the FPGA image-filter datapath. It takes a full 81-pixel neighbourhood (10-bit pixels) on a flat bus and produces the mean as one 10-bit output pixel. A computation starts on a `refresh` pulse and the result comes out of a fixed-latency pipeline. It sits between the window/line-buffer memory (which drives `data_bus`) and the output pixel writer.

## Interface
Parameters: none (the geometry of 81 pixels × 10 bits is fixed).

- `clk`  in  1  rising-edge clock, the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `data_bus`  in  810  81 pixels, unsigned 10 bits each
  - pixel i = `data_bus[10*i+9 : 10*i]`
  - i = row*9 + col; row 0 / col 0 sit at the LSBs
- `refresh`  in  1  start strobe, sampled on `clk` rising edge
- `out`  out  10  filtered pixel, registered; holds its last value between results

## Operation
- A rising edge of `clk` with `refresh`=1 captures `data_bus` into the input register and sets a valid tag.
- Edges with `refresh`=0 capture nothing, and the valid tag stays 0.
- Stage 1: nine row sums, each the sum of 9 pixels, 14 bits unsigned.
- Stage 2: total sum S of the nine row sums, 17 bits unsigned; maximum value 81×1023 = 82863.
- Stage 3: `out` <= round(S/81) = floor((S+40)/81).
  - Result range is 0..1023, so no saturation is needed.
  - Division by a constant is allowed, e.g. multiply by a reciprocal. The result must be bit-exact for every S in 0..82863.
- Valid tags travel alongside the data. `out` updates only when a tagged item reaches stage 3; otherwise it holds.
- Fully pipelined: `refresh` may be high on consecutive cycles, and each capture yields its own result in order.
- `data_bus` may change freely on any cycle without `refresh`; it has no effect.
- Reset:
  - Clears all pipeline data registers, all valid tags and `out`, so `out` = 0.
  - Any in-flight results are discarded and never appear.
- `refresh` asserted on the first edge after reset deasserts is captured normally.

## Timing
- Capture edge N (`refresh`=1): `out` shows the result after edge N+3, a latency of 3 cycles.
- Throughput: one result per clock.
- Reset is asynchronous and takes effect immediately. Deassertion is released on a clock edge by the system; the block needs no synchronizer.
- While `refresh`=0 continuously, `out` is constant.

## Configuration
- Macro `OPERATION_ROUND_EN`:
  - Defined: round-half-up division, `out` = floor((S+40)/81).
  - Undefined: truncating division, `out` = floor(S/81).
- Latency, ports and all other behaviour are identical in both builds.

## Test plan
- Reset with `data_bus`=0 and `refresh`=0 held for 10 cycles -> `out`=0 throughout and after reset release.
- All 81 pixels = 1023, one `refresh` pulse -> `out`=1023 exactly 3 cycles after the capture edge, held afterwards.
- Pixel 0 = 40, rest 0 -> `out`=0. Pixel 0 = 41, rest 0 -> `out`=1 with `OPERATION_ROUND_EN`, 0 without. Pixel 40 = 81, rest 0 -> `out`=1 in both builds.
- Back-to-back `refresh` on 3 consecutive cycles:
  - data all 81 (pixels = 81), then all 162, then all 0
  - -> `out` = 81, 162, 0 on consecutive cycles starting 3 cycles after the first capture.
- `rst` asserted 1 cycle after a capture of all-1023 -> `out` = 0 immediately, and 1023 never appears.
- Random `data_bus` with random `refresh` over 10k cycles -> `out` matches the reference mean model with a 3-cycle delay, and holds when there is no result.

Source files
------------

// File: rtl/operation.sv
// operation: 9x9 box-mean filter, 81 x 10-bit pixels -> one 10-bit mean, 3-cycle latency.
// Build macro OPERATION_ROUND_EN selects round-half-up; otherwise the mean is truncated.
module operation (
  input  logic         clk,
  input  logic         rst,
  input  logic [809:0] data_bus,
  input  logic         refresh,
  output logic [9:0]   out
);

  localparam int N  = 9;
  localparam int PW = 10;

  typedef logic [PW-1:0] pix_t;
  typedef logic [13:0]   row_t;
  typedef logic [16:0]   sum_t;

  // floor(x/81) == (x*207127)>>24 holds for all x < 2^24/71
  localparam logic [34:0] RECIP = 35'd207127;
  localparam int          SHIFT = 24;

  logic [N*N*PW-1:0] win_q;
  logic              v0_q;

  row_t              row_d [N];
  row_t              row_q [N];
  logic              v1_q;

  sum_t              sum_d;
  sum_t              sum_q;
  logic              v2_q;

  sum_t              num;
  logic [34:0]       prod;
  pix_t              quo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
      v0_q  <= 1'b0;
    end else begin
      v0_q <= refresh;
      if (refresh) begin
        win_q <= data_bus;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      row_d[r] = '0;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        row_d[r] = row_d[r]
                 + row_t'(win_q[PW*(r*N+c) +: PW]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        row_q[r] <= '0;
      end
      v1_q <= 1'b0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        for (int r = 0; r < N; r++) begin
          row_q[r] <= row_d[r];
        end
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int r = 0; r < N; r++) begin
      sum_d = sum_d + sum_t'(row_q[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q <= sum_d;
      end
    end
  end

`ifdef OPERATION_ROUND_EN
  assign num = sum_q + sum_t'(40);
`else
  assign num = sum_q;
`endif

  assign prod = {18'd0, num} * RECIP;
  assign quo  = PW'(prod >> SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (v2_q) begin
      out <= quo;
    end
  end

endmodule

// File: tb/tb_operation.sv
// tb_operation: directed table, corner sequences and random traffic
// checked against a queue-based mean model for the operation filter.
module tb_operation;

  logic         clk = 1'b0;
  logic         rst;
  logic [809:0] data_bus;
  logic         refresh;
  logic [9:0]   out;

  operation dut (
    .clk      (clk),
    .rst      (rst),
    .data_bus (data_bus),
    .refresh  (refresh),
    .out      (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   val;
  } ent_t;

  typedef struct {
    string        name;
    logic [809:0] bus;
    int           exp;
  } vec_t;

  ent_t pipe_q[$];
  vec_t tbl[7];
  int   exp_out = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  function automatic int mean_ref(logic [809:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 81; i++) s += int'(b[10*i +: 10]);
`ifdef OPERATION_ROUND_EN
    return (s + 40) / 81;
`else
    return s / 81;
`endif
  endfunction

  function automatic logic [809:0] all_pix(int v);
    logic [809:0] b;
    for (int i = 0; i < 81; i++) b[10*i +: 10] = 10'(v);
    return b;
  endfunction

  function automatic logic [809:0] one_pix(int idx, int v);
    logic [809:0] b;
    b = '0;
    b[10*idx +: 10] = 10'(v);
    return b;
  endfunction

  function automatic logic [809:0] bus_for_sum(int s);
    logic [809:0] b;
    int rem;
    int p;
    rem = s;
    for (int i = 0; i < 81; i++) begin
      p = (rem > 1023) ? 1023 : rem;
      b[10*i +: 10] = 10'(p);
      rem -= p;
    end
    return b;
  endfunction

  function automatic logic [809:0] rand_bus();
    logic [809:0] b;
    int mode;
    mode = int'($urandom_range(0, 7));
    for (int i = 0; i < 81; i++) begin
      if (mode == 0)      b[10*i +: 10] = 10'd1023;
      else if (mode == 1) b[10*i +: 10] = 10'd0;
      else                b[10*i +: 10] = 10'($urandom_range(0, 1023));
    end
    return b;
  endfunction

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: out=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(logic [809:0] b, logic r);
    ent_t e;
    data_bus = b;
    refresh  = r;
    e.v   = r;
    e.val = mean_ref(b);
    pipe_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (pipe_q.size() > 3) begin
      e = pipe_q.pop_front();
      if (e.v) exp_out = e.val;
    end
    check("model", int'(out), exp_out);
  endtask

  task automatic model_reset();
    pipe_q.delete();
    exp_out = 0;
  endtask

  initial begin
    int svals[$];
    int k;

    tbl[0] = '{"all_1023", all_pix(1023), 1023};
    tbl[1] = '{"p0_40", one_pix(0, 40), 0};
`ifdef OPERATION_ROUND_EN
    tbl[2] = '{"p0_41", one_pix(0, 41), 1};
    tbl[6] = '{"alt_1023", '0, 518};
`else
    tbl[2] = '{"p0_41", one_pix(0, 41), 0};
    tbl[6] = '{"alt_1023", '0, 517};
`endif
    tbl[3] = '{"p40_81", one_pix(40, 81), 1};
    tbl[4] = '{"all_81", all_pix(81), 81};
    tbl[5] = '{"all_500", all_pix(500), 500};
    for (int i = 0; i < 81; i += 2) tbl[6].bus[10*i +: 10] = 10'd1023;

    rst      = 1'b1;
    refresh  = 1'b0;
    data_bus = '0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", int'(out), 0);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle('0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      cycle(tbl[t].bus, 1'b1);
      cycle(rand_bus(), 1'b0);
      cycle(rand_bus(), 1'b0);
      cycle(rand_bus(), 1'b0);
      check(tbl[t].name, int'(out), tbl[t].exp);
      cycle(rand_bus(), 1'b0);
      check({tbl[t].name, "_hold"}, int'(out), tbl[t].exp);
    end

    cycle(all_pix(81), 1'b1);
    cycle(all_pix(162), 1'b1);
    cycle(all_pix(0), 1'b1);
    cycle(rand_bus(), 1'b0);
    check("b2b_0", int'(out), 81);
    cycle(rand_bus(), 1'b0);
    check("b2b_1", int'(out), 162);
    cycle(rand_bus(), 1'b0);
    check("b2b_2", int'(out), 0);

    cycle(all_pix(500), 1'b1);
    for (int i = 0; i < 3; i++) cycle('0, 1'b0);
    check("pre_rst", int'(out), 500);
    cycle(all_pix(1023), 1'b1);
    rst = 1'b1;
    refresh = 1'b0;
    #1;
    check("rst_async", int'(out), 0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_held", int'(out), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(rand_bus(), 1'b0);
      check("no_leak", int'(out), 0);
    end

    svals = '{0, 40, 41, 80, 81, 121, 122, 82822, 82823, 82862, 82863};
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 1021));
      svals.push_back(81*k + 40);
      svals.push_back(81*k + 41);
      svals.push_back(81*k + 80);
    end
    foreach (svals[i]) cycle(bus_for_sum(svals[i]), 1'b1);
    for (int i = 0; i < 4; i++) cycle('0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      cycle(rand_bus(), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) cycle('0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
